// File: rtl/cpu_pkg.sv
// Shared core definitions: datapath width, forwarding-select codes, bubble
// value and the select-width helper used by the pipelined select stages.
package cpu_pkg;

    localparam int XLEN = 32;

    // Forwarding-select encodings used at the ID/EX operand muxes.
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    // Value a pipeline register takes when a bubble is inserted.
    localparam logic [XLEN-1:0] PIPE_BUBBLE = '0;

    // Binary select width for an n-input mux, never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pipe_mux_n_if.sv
// Operand/control bundle of the registered N-to-1 select stage. The master
// side feeds operands and pipeline control; the slave side is the stage.
interface pipe_mux_n_if
    import cpu_pkg::*;
#(
    parameter int WIDTH  = XLEN,
    parameter int NUM_IN = 3
);

    localparam int SEL_W = sel_width(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic                    in_valid;
    logic [SEL_W-1:0]        sel;
    logic                    stall;
    logic                    flush;
    logic                    err_clr;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic [SEL_W-1:0]        out_sel;
    logic                    sel_err;

    modport master (
        output in_data, in_valid, sel, stall, flush, err_clr,
        input  out_data, out_valid, out_sel, sel_err
    );

    modport slave (
        input  in_data, in_valid, sel, stall, flush, err_clr,
        output out_data, out_valid, out_sel, sel_err
    );

endinterface

// File: rtl/mux_nto1.sv
// Combinational N-to-1 selector. An out-of-range select falls back to
// input 0 and is reported on 'illegal'.
module mux_nto1
    import cpu_pkg::*;
#(
    parameter int WIDTH  = XLEN,
    parameter int NUM_IN = 3,
    localparam int SEL_W = sel_width(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        eff_sel,
    output logic                    illegal
);

    // Decode the select, then pick the operand addressed by the effective select.
    always_comb begin
        // NOTE: every output gets a default before any conditional write, so no latch is inferred.
        illegal  = 1'b1;
        out_data = in_data[WIDTH-1:0];
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) illegal = 1'b0;
        end
        eff_sel = illegal ? '0 : sel;
        for (int k = 0; k < NUM_IN; k++) begin
            if (eff_sel == SEL_W'(k)) out_data = in_data[k*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/pipe_mux_n.sv
// Registered N-to-1 select stage: mux plus pipeline register with valid
// tracking, stall hold, flush-to-bubble and a sticky illegal-select flag.
module pipe_mux_n
    import cpu_pkg::*;
#(
    parameter int              WIDTH     = XLEN,
    parameter int              NUM_IN    = 3,
    parameter logic [WIDTH-1:0] FLUSH_VAL = WIDTH'(PIPE_BUBBLE)
) (
    input logic         clk,
    input logic         rst,
    pipe_mux_n_if.slave bus
);

    localparam int SEL_W = sel_width(NUM_IN);

    logic [WIDTH-1:0] mux_data;
    logic [SEL_W-1:0] mux_sel;
    logic             mux_illegal;

    logic [WIDTH-1:0] out_data_d,  out_data_q;
    logic             out_valid_d, out_valid_q;
    logic [SEL_W-1:0] out_sel_d,   out_sel_q;
    logic             sel_err_d,   sel_err_q;
    logic             load;

    mux_nto1 #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_mux (
        .in_data  (bus.in_data),
        .sel      (bus.sel),
        .out_data (mux_data),
        .eff_sel  (mux_sel),
        .illegal  (mux_illegal)
    );

    // Next-state: flush beats stall beats load; the error flag's set beats its clear.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_sel_d   = out_sel_q;
        sel_err_d   = sel_err_q;
        load        = !bus.flush && !bus.stall;

        if (bus.flush) begin
            out_data_d  = FLUSH_VAL;
            out_valid_d = 1'b0;
            out_sel_d   = '0;
        end else if (load) begin
            out_data_d  = mux_data;
            out_valid_d = bus.in_valid;
            out_sel_d   = mux_sel;
        end

        if (bus.err_clr)                          sel_err_d = 1'b0;
        if (load && bus.in_valid && mux_illegal)  sel_err_d = 1'b1;
    end

    // Output registers with synchronous reset taking priority over all controls.
    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sel_q   <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.sel_err   = sel_err_q;

endmodule

// File: doc/pipe_mux_n.md
Name: pipe_mux_n

Overview:
- Parametrised, registered N-to-1 select stage for the pipelined RISC-V core; successor to the 3-input combinational mux.
- Selects one of NUM_IN packed operands and registers the result with valid tracking, stall hold, flush-to-bubble and a sticky illegal-select flag.
- Used at ID/EX forwarding points, where the mux output and the pipeline register are one block.

Parameters:
- WIDTH, 32, data width per input.
- NUM_IN, 3, number of inputs; legal range 2..16.
- FLUSH_VAL, 0, WIDTH-bit value loaded into out_data on flush.
- SEL_W, derived localparam = max(1, clog2(NUM_IN)); not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_data  in  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_valid  in  1  upstream data qualifier.
- sel  in  SEL_W  binary select.
- stall  in  1  hold all output registers.
- flush  in  1  insert a bubble.
- err_clr  in  1  clear sel_err.
- out_data  out  WIDTH  registered selected data.
- out_valid  out  1  registered valid.
- out_sel  out  SEL_W  registered effective select (debug/trace).
- sel_err  out  1  sticky illegal-select flag.

Behaviour:
- Reset: out_data=0, out_valid=0, out_sel=0, sel_err=0; rst overrides every other input.
- Latency: 1 cycle from sel/in_data/in_valid to out_*; no combinational path from inputs to outputs.
- Effective select: sel<NUM_IN uses input sel. sel>=NUM_IN is illegal and forces input 0 (matches the legacy default arm).
- Per-edge priority: rst > flush > stall > load.
- flush: out_data=FLUSH_VAL, out_valid=0, out_sel=0. flush wins over a simultaneous stall.
- stall (no flush): out_data, out_valid and out_sel hold.
- load (neither flush nor stall): out_data=selected input, out_valid=in_valid, out_sel=effective select.
  - Data is loaded even when in_valid=0; consumers qualify with out_valid.
- sel_err: set on any load edge where in_valid=1 and sel>=NUM_IN.
  - Not set during stall, flush, or when in_valid=0.
  - Cleared by err_clr or rst. Set wins over a simultaneous err_clr.
- Power-of-two NUM_IN: no illegal select exists, so sel_err stays 0.
- rst asserted mid-stall or mid-flush: reset values on the next edge; stall/flush history is not retained.
- No internal state besides the output registers and sel_err. A single-cycle stall or flush has no after-effects.

Decomposition:
- Package cpu_pkg holds:
  - XLEN=32.
  - Forwarding-select encodings FWD_RF=2'd0, FWD_MEM=2'd1, FWD_WB=2'd2.
  - PIPE_BUBBLE constant (default FLUSH_VAL source).
- One sub-module, mux_nto1: combinational (WIDTH, NUM_IN) selector with an illegal-select output.
  - pipe_mux_n instantiates it and adds the register/control logic.

Test Plan (WIDTH=32, NUM_IN=3 unless stated):
- Reset and basic load:
  - Stimulus: rst 2 cycles, then in_data={0xCCCC0002,0xBBBB0001,0xAAAA0000}, sel=1, in_valid=1.
  - Response: out_* all 0 during rst; one edge after release, out_data=0xBBBB0001, out_valid=1, out_sel=1.
- Stall hold:
  - Stimulus: load sel=2, then stall=1 for 3 cycles while sel=0 and in_data changes.
  - Response: out_data stays 0xCCCC0002 and out_valid stays 1 for all 3 cycles; first edge after stall drops loads input 0.
- Flush priority:
  - Stimulus: stall=1 and flush=1 on the same edge, out_valid=1 beforehand.
  - Response: out_data=0, out_valid=0, out_sel=0 next cycle.
- Illegal select:
  - Stimulus: sel=3 with in_valid=1.
  - Response: out_data=0xAAAA0000, out_sel=0, sel_err=1. With sel=3 and in_valid=0, sel_err stays 0.
- sel_err clear/set race:
  - Stimulus: sel_err=1, then err_clr=1 with a legal sel.
  - Response: sel_err=0 next cycle.
  - Stimulus: err_clr=1 together with sel=3, in_valid=1.
  - Response: sel_err stays 1.
- Generalised sizes:
  - Stimulus: NUM_IN=4, WIDTH=8, sweep sel 0..3 with in_valid=1.
  - Response: each input is observed with 1-cycle latency; sel_err never sets.
  - Stimulus: NUM_IN=5, sel=7.
  - Response: sel_err=1.
